// File: rtl/game_flow_controller.sv
// Frame-paced round sequencer for Frogger: start, ready delay, play, hit freeze,
// level transition and game over, with lives/level bookkeeping and frog re-spawn.
package gfc_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READY     = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_HIT       = 3'd3,
    ST_LEVEL     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_e;
endpackage

module game_flow_controller
  import gfc_pkg::*;
#(
  parameter int C_LIVES_INI    = 3,
  parameter int C_START_FRAMES = 60,
  parameter int C_HIT_FRAMES   = 90,
  parameter int C_LEVEL_FRAMES = 60
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Has_Collided,
  input  logic       i_Level_Up,
  output logic       o_Game_Active,
  output logic       o_Frog_Reset,
  output logic [1:0] o_Lives,
  output logic [2:0] o_Level,
  output logic [2:0] o_State,
  output logic       o_Game_Over,
  output logic       o_Flash
);

  localparam logic [1:0] LIVES_INI    = 2'(C_LIVES_INI);
  localparam logic [7:0] START_FRAMES = 8'(C_START_FRAMES);
  localparam logic [7:0] HIT_FRAMES   = 8'(C_HIT_FRAMES);
  localparam logic [7:0] LEVEL_FRAMES = 8'(C_LEVEL_FRAMES);
  localparam logic [2:0] LEVEL_MAX    = 3'd7;

  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [1:0] lives_q, lives_d;
  logic [2:0] level_q, level_d;
  logic       start_prev_q;
  logic       game_active_q;
  logic       frog_reset_q;
  logic       game_over_q;

  logic       start_edge;
  logic [7:0] cnt_inc;
  logic [7:0] timer_limit;
  logic       timer_done;

  assign start_edge = i_Start & ~start_prev_q;
  assign cnt_inc    = frame_cnt_q + 8'd1;

  // A timed state leaves on the tick that brings the count up to its limit.
  always_comb begin
    unique case (state_q)
      ST_READY: timer_limit = START_FRAMES;
      ST_HIT:   timer_limit = HIT_FRAMES;
      ST_LEVEL: timer_limit = LEVEL_FRAMES;
      default:  timer_limit = 8'd0;
    endcase
  end

  assign timer_done = i_Frame_Tick && (timer_limit != 8'd0) && (cnt_inc == timer_limit);

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_edge) begin
          lives_d = LIVES_INI;
          level_d = 3'd0;
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (timer_done) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (i_Has_Collided) begin
          lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          state_d = ST_HIT;
        end else if (i_Level_Up) begin
          level_d = (level_q != LEVEL_MAX) ? level_q + 3'd1 : LEVEL_MAX;
          state_d = ST_LEVEL;
        end
      end
      ST_HIT: begin
        if (timer_done) state_d = (lives_q == 2'd0) ? ST_GAME_OVER : ST_READY;
      end
      ST_LEVEL: begin
        if (timer_done) state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase

    // A tick coinciding with a state change belongs to the old state.
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else if (i_Frame_Tick && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_d = cnt_inc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q       <= ST_IDLE;
      frame_cnt_q   <= 8'd0;
      lives_q       <= LIVES_INI;
      level_q       <= 3'd0;
      start_prev_q  <= 1'b1;
      game_active_q <= 1'b0;
      frog_reset_q  <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      start_prev_q  <= i_Start;
      game_active_q <= (state_d == ST_RUNNING);
      frog_reset_q  <= (state_d == ST_READY) && (state_q != ST_READY);
      game_over_q   <= (state_d == ST_GAME_OVER);
    end
  end

  assign o_State       = state_q;
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;
  assign o_Game_Active = game_active_q;
  assign o_Frog_Reset  = frog_reset_q;
  assign o_Game_Over   = game_over_q;
  assign o_Flash       = (state_q == ST_HIT) && frame_cnt_q[3];

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: scripted round-flow vectors, a long-HIT blink
// check, unused-encoding recovery and randomized play against a reference model.
module tb_game_flow_controller;
  import gfc_pkg::*;

  localparam int LIVES   = 2;
  localparam int START_N = 2;
  localparam int HIT_N   = 4;
  localparam int LEVEL_N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l, start, tick, coll, lvl;

  logic       active, freset, over, flash;
  logic [1:0] lives;
  logic [2:0] level, state;
  logic       active16, freset16, over16, flash16;
  logic [1:0] lives16;
  logic [2:0] level16, state16;
  logic [11:0] got, got16;

  assign got   = {state, lives, level, active, freset, over, flash};
  assign got16 = {state16, lives16, level16, active16, freset16, over16, flash16};

  game_flow_controller #(
    .C_LIVES_INI(LIVES), .C_START_FRAMES(START_N),
    .C_HIT_FRAMES(HIT_N), .C_LEVEL_FRAMES(LEVEL_N)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Frame_Tick(tick), .i_Start(start),
    .i_Has_Collided(coll), .i_Level_Up(lvl),
    .o_Game_Active(active), .o_Frog_Reset(freset), .o_Lives(lives),
    .o_Level(level), .o_State(state), .o_Game_Over(over), .o_Flash(flash)
  );

  game_flow_controller #(
    .C_LIVES_INI(LIVES), .C_START_FRAMES(START_N),
    .C_HIT_FRAMES(16), .C_LEVEL_FRAMES(LEVEL_N)
  ) dut16 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Frame_Tick(tick), .i_Start(start),
    .i_Has_Collided(coll), .i_Level_Up(lvl),
    .o_Game_Active(active16), .o_Frog_Reset(freset16), .o_Lives(lives16),
    .o_Level(level16), .o_State(state16), .o_Game_Over(over16), .o_Flash(flash16)
  );

  typedef struct {
    logic        rst_l, start, tick, coll, lvl;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic rl, st, tk, co, lu,
                              input logic [2:0] s, input logic [1:0] l, input logic [2:0] v,
                              input logic a, r, o, f);
    vec_t t;
    t.rst_l = rl; t.start = st; t.tick = tk; t.coll = co; t.lvl = lu;
    t.exp = {s, l, v, a, r, o, f};
    return t;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (state,lives,level,act,frst,over,flash)",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic rl, st, tk, co, lu);
    rst_l = rl; start = st; tick = tk; coll = co; lvl = lu;
    @(negedge clk);
  endtask

  // Reference model: phase in output encoding plus a countdown of ticks left.
  int m_state, m_left, m_lives, m_level;
  bit m_prev, m_fr;

  task automatic model_ready();
    m_state = 1; m_left = START_N; m_fr = 1'b1;
  endtask

  task automatic model_step(input logic rl, st, tk, co, lu);
    bit edge_s;
    if (!rl) begin
      m_state = 0; m_left = 0; m_lives = LIVES; m_level = 0; m_prev = 1'b1; m_fr = 1'b0;
      return;
    end
    edge_s = st && !m_prev;
    m_prev = st;
    m_fr   = 1'b0;
    case (m_state)
      0, 5: if (edge_s) begin m_lives = LIVES; m_level = 0; model_ready(); end
      1: if (tk) begin m_left--; if (m_left == 0) m_state = 2; end
      2: if (co) begin
           m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_state = 3; m_left = HIT_N;
         end else if (lu) begin
           m_level = (m_level < 7) ? m_level + 1 : 7; m_state = 4; m_left = LEVEL_N;
         end
      3: if (tk) begin
           m_left--;
           if (m_left == 0) begin
             if (m_lives == 0) m_state = 5; else model_ready();
           end
         end
      4: if (tk) begin m_left--; if (m_left == 0) model_ready(); end
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [11:0] model_exp();
    logic f;
    f = (m_state == 3) && ((((HIT_N - m_left) >> 3) & 1) == 1);
    return {3'(m_state), 2'(m_lives), 3'(m_level),
            logic'(m_state == 2), m_fr, logic'(m_state == 5), f};
  endfunction

  initial begin
    rst_l = 1'b0; start = 1'b1; tick = 1'b0; coll = 1'b0; lvl = 1'b0;

    //            rl st tk co lu   S  L  V  A  R  O  F
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 2, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  2, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  2, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1,  4, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  4, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  4, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 2, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  2, 2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1,  3, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  3, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  3, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  3, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0,  3, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  3, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  3, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  3, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  5, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  5, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  5, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 2, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1,  1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  2, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  2, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0,  3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst_l, vecs[i].start, vecs[i].tick, vecs[i].coll, vecs[i].lvl);
      check($sformatf("vec%0d", i), got, vecs[i].exp);
    end

    // Long HIT on the 16-frame instance: blink is counter bit 3.
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 1, 0);
    check("hit16_entry", got16, {3'd3, 2'd1, 3'd0, 4'b0000});
    for (int k = 0; k < 16; k++) begin
      check($sformatf("flash16_t%0d", k), {11'd0, flash16}, {11'd0, logic'(k >= 8)});
      drive(1, 1, 1, 0, 0);
    end
    check("hit16_exit", {9'd0, state16}, 12'd1);

    // Unused encoding recovers to IDLE.
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    check("running_before_force", {9'd0, state}, 12'd2);
    rst_l = 1'b1; start = 1'b1; tick = 1'b0; coll = 1'b0; lvl = 1'b0;
    force dut.state_q = state_e'(3'd6);
    #1 check("forced_enc6", {9'd0, state}, 12'd6);
    @(posedge clk);
    #1 release dut.state_q;
    @(negedge clk);
    @(negedge clk);
    check("enc6_to_idle", got, {3'd0, 2'd2, 3'd0, 4'b0000});

    // Randomized play against the model.
    drive(0, 1, 0, 0, 0);
    model_step(0, 1, 0, 0, 0);
    check("rand_reset", got, model_exp());
    begin
      logic st_r;
      st_r = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        logic rl_r, tk_r, co_r, lu_r;
        rl_r = ($urandom_range(0, 299) != 0);
        if ($urandom_range(0, 9) == 0) st_r = ~st_r;
        tk_r = ($urandom_range(0, 1) == 0);
        co_r = ($urandom_range(0, 5) == 0);
        lu_r = ($urandom_range(0, 4) == 0);
        model_step(rl_r, st_r, tk_r, co_r, lu_r);
        drive(rl_r, st_r, tk_r, co_r, lu_r);
        check($sformatf("rand%0d", c), got, model_exp());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Frame-paced game sequencer for the Frogger top level. It replaces the two-state IDLE/RUNNING machine with a full round flow: start, ready delay, play, hit/death freeze, level transition and game over. It also tracks lives and level, gates movement via `o_Game_Active`, and commands frog re-spawn. Inputs come from the debounced switches, `Collisions` and `Character_Control`, and one frame tick from the VGA sync chain.

## Interface
Parameters:
- `C_LIVES_INI`, 3: lives loaded at game start; legal 1..3.
- `C_START_FRAMES`, 60: frame ticks spent in READY; legal 1..255.
- `C_HIT_FRAMES`, 90: frame ticks spent in HIT; legal 1..255.
- `C_LEVEL_FRAMES`, 60: frame ticks spent in LEVEL; legal 1..255.

Ports:
- `i_Clk`, in, 1: system clock. One clock; reset is synchronous and active-low.
- `i_Rst_L`, in, 1: synchronous active-low reset.
- `i_Frame_Tick`, in, 1: one-cycle pulse per video frame.
- `i_Start`, in, 1: debounced "all switches pressed" level.
- `i_Has_Collided`, in, 1: frog/car overlap level.
- `i_Level_Up`, in, 1: one-cycle pulse when the frog reaches the goal.
- `o_Game_Active`, out, 1: high only in RUNNING.
- `o_Frog_Reset`, out, 1: one-cycle pulse that returns the frog to its base position.
- `o_Lives`, out, 2: remaining lives.
- `o_Level`, out, 3: current level, 0..7.
- `o_State`, out, 3: encoding IDLE=0, READY=1, RUNNING=2, HIT=3, LEVEL=4, GAME_OVER=5.
- `o_Game_Over`, out, 1: high only in GAME_OVER.
- `o_Flash`, out, 1: frog blink enable during HIT.

## Operation
- Start edge: `r_Start_Prev` registers `i_Start`. An edge is `i_Start & ~r_Start_Prev`. Only edges are used, never levels.
- Frame counter: 8 bits. Clears on every state change. Increments on `i_Frame_Tick` while the state register holds the current state.
- A timed state exits on the tick that makes the count equal to its parameter N, i.e. the Nth tick after entry.
- IDLE:
  - On a start edge: lives ← `C_LIVES_INI`, level ← 0, then go to READY.
- READY:
  - After `C_START_FRAMES` ticks, go to RUNNING.
  - Collision and level-up inputs are ignored.
- RUNNING:
  - `i_Has_Collided`=1: lives ← lives−1, saturating at 0; go to HIT.
  - Otherwise `i_Level_Up`=1: level ← level+1, saturating at 7; go to LEVEL.
  - If both arrive in the same cycle, collision wins and the level-up pulse is dropped.
- HIT:
  - After `C_HIT_FRAMES` ticks: if lives==0, go to GAME_OVER; otherwise go to READY.
  - `o_Flash` = frame counter bit 3; it is 0 in every other state.
- LEVEL:
  - After `C_LEVEL_FRAMES` ticks, go to READY. Lives are unchanged.
- GAME_OVER:
  - `o_Lives`=0 and `o_Level` are held.
  - On a start edge: reload lives and level as in IDLE, then go to READY.
- `o_Frog_Reset` pulses on every entry into READY, from any source state.
- Unused encodings 6 and 7 go to IDLE on the next clock.
- All other inputs are ignored outside the states listed above.

## Timing
- Reset, with `i_Rst_L`=0 sampled on an edge:
  - State IDLE, `o_Lives`=`C_LIVES_INI`, `o_Level`=0.
  - `o_Game_Active`, `o_Frog_Reset`, `o_Game_Over` and `o_Flash` all 0; counter 0.
  - `r_Start_Prev`=1, so switches held through reset do not start a game.
  - Reset mid-game aborts immediately; no frog reset pulse is issued.
- All outputs are registered or decoded from registered state. They change on the clock edge after the qualifying input is sampled.
- `o_Frog_Reset` is high for exactly the first clock cycle in which `o_State`=READY.
- `o_Lives` and `o_Level` update on the same edge that changes `o_State`.
- `o_Game_Active` drops on the edge where a collision is registered, so the frog cannot move in that next cycle.
- A tick and a state change in the same cycle: the counter clears, and the tick is not counted for the new state.
- Counter saturates at 255; it cannot wrap inside a legal timed state.

## Test plan
Use `C_LIVES_INI`=2, `C_START_FRAMES`=2, `C_HIT_FRAMES`=4, `C_LEVEL_FRAMES`=3.
- Reset release with `i_Start`=1 held: state stays 0. Drop `i_Start` then raise it → state 1, `o_Frog_Reset` for 1 cycle, `o_Lives`=2, `o_Level`=0. Two ticks → state 2, `o_Game_Active`=1.
- In RUNNING, pulse `i_Level_Up` → state 4, `o_Level`=1. Three ticks → state 1 with `o_Frog_Reset` pulse. Two ticks → state 2.
- In RUNNING, assert `i_Has_Collided` and `i_Level_Up` in the same cycle → state 3, `o_Lives`=1, `o_Level` unchanged. `o_Flash`=0 for ticks 0-3. Fourth tick → state 1.
- Second collision → `o_Lives`=0. Four ticks → state 5, `o_Game_Over`=1. Hold `i_Start` high from earlier: no restart. New start edge → state 1, `o_Lives`=2, `o_Level`=0.
- With `C_HIT_FRAMES`=16, hold HIT: `o_Flash` is 0 for ticks 0-7 and 1 for ticks 8-15.
- Pull `i_Rst_L` low mid-HIT for one edge → state 0, `o_Lives`=2, all 1-bit outputs 0. Also force state 6 → state 0 on the next edge.
